// File: rtl/obc_pkg.sv
// Shared definitions for the OBC distributed-arithmetic DFT datapath.
package obc_pkg;

  localparam int unsigned N_PTS = 16;
  localparam int unsigned W_DEF = 16;

  typedef logic [N_PTS-1:0] plane_t;

  // Counter width able to hold 0..w-1.
  function automatic int unsigned cnt_w(input int unsigned w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/obc_plane_shreg.sv
// Bank of N_PTS W-bit shift registers: parallel load, per-sample right shift, hold.
module obc_plane_shreg
  import obc_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [N_PTS*W-1:0] load_data,
  output plane_t             lsbs
);

  logic [N_PTS*W-1:0] sr_q;
  logic [N_PTS*W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_data;
    end else if (shift) begin
      for (int k = 0; k < N_PTS; k++) begin
        sr_d[k*W +: W] = {1'b0, sr_q[k*W+1 +: W-1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  always_comb begin
    lsbs = '0;
    for (int k = 0; k < N_PTS; k++) lsbs[k] = sr_q[k*W];
  end

endmodule

// File: rtl/obc_bitplane_serializer.sv
// Serializes 16-sample frames into LSB-first bit-planes, with a one-frame shadow
// buffer so consecutive frames stream without idle planes.
module obc_bitplane_serializer
  import obc_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PTS*W-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output plane_t             bp,
  output logic               msb_flag,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int unsigned CNT_W = cnt_w(W);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(W - 1);

  typedef enum logic [1:0] {StIdle, StShift, StShiftFull} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_PTS*W-1:0] s_q;
  logic               s_load;
  logic               sr_load, sr_shift;
  logic [N_PTS*W-1:0] sr_load_data;
  plane_t             sr_lsbs;
  logic               busy, shadow_full, accept, fire, last;

  assign busy        = (state_q != StIdle);
  assign shadow_full = (state_q == StShiftFull);
  assign in_ready    = !shadow_full;
  assign accept      = in_valid && in_ready;
  assign fire        = busy && out_ready;
  assign last        = (cnt_q == CntLast);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    s_load       = 1'b0;
    sr_load      = 1'b0;
    sr_shift     = 1'b0;
    sr_load_data = in_data;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sr_load = 1'b1;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (fire && last) begin
          cnt_d = '0;
          // A frame arriving on the last plane bypasses the shadow.
          if (accept) sr_load = 1'b1;
          else        state_d = StIdle;
        end else begin
          if (fire) begin
            sr_shift = 1'b1;
            cnt_d    = cnt_q + 1'b1;
          end
          if (accept) begin
            s_load  = 1'b1;
            state_d = StShiftFull;
          end
        end
      end
      StShiftFull: begin
        if (fire && last) begin
          sr_load      = 1'b1;
          sr_load_data = s_q;
          cnt_d        = '0;
          state_d      = StShift;
        end else if (fire) begin
          sr_shift = 1'b1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (s_load) s_q <= in_data;
    end
  end

  obc_plane_shreg #(
    .W (W)
  ) u_sr (
    .clk       (clk),
    .rst       (rst),
    .load      (sr_load),
    .shift     (sr_shift),
    .load_data (sr_load_data),
    .lsbs      (sr_lsbs)
  );

  assign out_valid = busy;
  assign bp        = busy ? sr_lsbs : '0;
  assign msb_flag  = busy && last;

endmodule

// File: tb/tb_obc_bitplane_serializer.sv
// Randomized bench: a frame-queue reference model predicts every output cycle by cycle.
module tb_obc_bitplane_serializer;
  import obc_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned DW = N_PTS * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  plane_t        bp;
  logic          msb_flag;
  logic          out_valid;
  logic          out_ready;

  obc_bitplane_serializer #(
    .W (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bp        (bp),
    .msb_flag  (msb_flag),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Frames in flight, oldest first; pidx is the plane being presented from fq[0].
  logic [DW-1:0] fq[$];
  int            pidx = 0;
  logic [15:0]   cap[$];
  logic          last_acc;
  logic          rand_ready = 1'b0;
  logic          prev_stall = 1'b0;
  logic [15:0]   prev_bp;
  logic          prev_msb;
  logic          prev_ov = 1'b0;
  int            valid_cnt, rises;
  logic [15:0]   tbl[16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: check outputs at the falling edge, then advance the model.
  task automatic step();
    logic [15:0] exp_bp;
    logic        exp_msb, exp_ov, acc, fire;
    @(negedge clk);
    exp_ov  = (fq.size() > 0);
    exp_bp  = '0;
    exp_msb = 1'b0;
    if (exp_ov) begin
      for (int k = 0; k < N_PTS; k++) exp_bp[k] = fq[0][k*W + pidx];
      exp_msb = (pidx == W - 1);
    end
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    check("bp", 32'(bp), 32'(exp_bp));
    check("msb_flag", 32'(msb_flag), 32'(exp_msb));
    check("in_ready", 32'(in_ready), 32'(fq.size() < 2));
    if (prev_stall) begin
      check("stall_bp", 32'(bp), 32'(prev_bp));
      check("stall_msb", 32'(msb_flag), 32'(prev_msb));
    end
    if (out_valid) valid_cnt++;
    if (out_valid && !prev_ov) rises++;
    prev_ov  = out_valid;
    acc      = in_valid && in_ready;
    fire     = out_valid && out_ready;
    last_acc = acc && !rst;
    if (rst) begin
      fq.delete();
      pidx       = 0;
      prev_stall = 1'b0;
    end else begin
      prev_stall = out_valid && !out_ready;
      prev_bp    = bp;
      prev_msb   = msb_flag;
      if (fire && fq.size() > 0) begin
        cap.push_back(bp);
        pidx++;
        if (pidx == W) begin
          void'(fq.pop_front());
          pidx = 0;
        end
      end
      if (acc) fq.push_back(in_data);
    end
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic offer(input logic [DW-1:0] f);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = f;
    last_acc = 1'b0;
    while (!last_acc && guard < 200) begin
      step();
      guard++;
    end
    if (!last_acc) check("offer_timeout", 32'(guard), 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    in_valid = 1'b0;
    while (fq.size() > 0 && guard < 400) begin
      step();
      guard++;
    end
    if (fq.size() > 0) check("drain_timeout", 32'(guard), 32'd0);
    step();
  endtask

  function automatic logic [DW-1:0] ramp_frame();
    logic [DW-1:0] f;
    for (int k = 0; k < N_PTS; k++) f[k*W +: W] = W'(k + 1);
    return f;
  endfunction

  function automatic logic [DW-1:0] rand_frame();
    logic [DW-1:0] f;
    for (int k = 0; k < N_PTS; k++) f[k*W +: W] = W'($urandom);
    return f;
  endfunction

  initial begin
    tbl[0] = 16'h5555; tbl[1] = 16'h6666; tbl[2] = 16'h7878; tbl[3] = 16'h7F80;
    tbl[4] = 16'h8000;
    for (int i = 5; i < 16; i++) tbl[i] = 16'h0000;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, then the ramp frame against the hand-derived plane table.
    step();
    cap.delete();
    offer(ramp_frame());
    drain();
    check("ramp_count", 32'(cap.size()), 32'd16);
    for (int i = 0; i < 16 && i < cap.size(); i++) check("ramp_plane", 32'(cap[i]), 32'(tbl[i]));

    // All-ones samples: every plane is all ones.
    cap.delete();
    offer({DW{1'b1}});
    drain();
    for (int i = 0; i < cap.size(); i++) check("neg_plane", 32'(cap[i]), 32'hFFFF);

    // Three frames offered back to back: one unbroken run of 48 valid planes.
    valid_cnt = 0; rises = 0;
    offer(rand_frame());
    offer(rand_frame());
    offer(rand_frame());
    drain();
    check("b2b_planes", 32'(valid_cnt), 32'd48);
    check("b2b_runs", 32'(rises), 32'd1);

    // Random backpressure: ramp frame followed by a frame waiting in the shadow.
    cap.delete();
    rand_ready = 1'b1;
    offer(ramp_frame());
    offer(rand_frame());
    drain();
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    for (int i = 0; i < 16 && i < cap.size(); i++) check("bp_plane", 32'(cap[i]), 32'(tbl[i]));

    // Reset at plane 7 with the shadow full.
    offer(rand_frame());
    offer(rand_frame());
    for (int g = 0; g < 100 && pidx != 7; g++) step();
    check("pre_rst_inflight", 32'(fq.size()), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bp", 32'(bp), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    offer(ramp_frame());
    cap.delete();
    drain();
    for (int i = 0; i < 16 && i < cap.size(); i++) check("post_rst_plane", 32'(cap[i]), 32'(tbl[i]));

    // Fully random traffic.
    rand_ready = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = rand_frame();
      step();
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
